counter_mod: RTL and testbench



---
 rtl/counter_pkg.sv | 11 +
 rtl/counter_prescaler.sv | 24 ++
 rtl/counter_mod.sv | 50 +++++
 tb/tb_counter_mod.sv | 137 +++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// counter_pkg: shared helpers and mode encodings for counter_mod
package counter_pkg;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT = 1;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) r = ((1 << i) < n) ? i + 1 : r;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: emits one step every PRESCALE enabled cycles
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sclr,
  output logic step
);
  localparam int PW = clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
  logic [PW-1:0] pc_q, pc_d;
  always_comb begin
    step = en && (pc_q == LAST);
    pc_d = (sclr || step) ? '0 : en ? pc_q + PW'(1) : pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) pc_q <= '0;
    else pc_q <= pc_d;
  end
endmodule

// File: rtl/counter_mod.sv
// counter_mod: parametrised up/down modulo counter with prescaler, clear, load and terminal-count pulse
module counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int MAX = 2 ** WIDTH - 1,
  parameter int PRESCALE = 1,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] val,
  output logic             tc,
  output logic             at_lim
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);
  logic [WIDTH-1:0] val_q, val_d, nxt;
  logic tc_q, tc_d, step;
  counter_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .sclr(clear | load),
    .step(step)
  );
  always_comb begin
    at_lim = up ? (val_q == MAXV) : (val_q == '0);
    // At a limit: saturate holds, wrap jumps to the opposite end of 0..MAX
    nxt = at_lim ? ((SATURATE == MODE_SAT) ? val_q : (up ? '0 : MAXV))
                 : (up ? val_q + WIDTH'(1) : val_q - WIDTH'(1));
    val_d = clear ? '0 : load ? ((load_val > MAXV) ? MAXV : load_val) : step ? nxt : val_q;
    tc_d = !clear && !load && step && at_lim;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      val_q <= '0;
      tc_q <= 1'b0;
    end else begin
      val_q <= val_d;
      tc_q <= tc_d;
    end
  end
  assign val = val_q;
  assign tc = tc_q;
endmodule

// File: tb/tb_counter_mod.sv
// tb_counter_mod: directed vector table plus hand sequences across four counter configurations
module tb_counter_mod;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;

  logic a_rst, a_en, a_up, a_clear, a_load, a_tc, a_al;
  logic [1:0] a_lv, a_val;
  logic b_rst, b_en, b_up, b_clear, b_load, b_tc, b_al;
  logic [3:0] b_lv, b_val;
  logic c_rst, c_en, c_up, c_clear, c_load, c_tc, c_al;
  logic [3:0] c_lv, c_val;
  logic d_rst, d_en, d_up, d_clear, d_load, d_tc, d_al;
  logic [3:0] d_lv, d_val;

  counter_mod u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .up(a_up), .clear(a_clear), .load(a_load),
    .load_val(a_lv), .val(a_val), .tc(a_tc), .at_lim(a_al)
  );
  counter_mod #(.WIDTH(4), .MAX(9)) u_b (
    .clk(clk), .rst(b_rst), .en(b_en), .up(b_up), .clear(b_clear), .load(b_load),
    .load_val(b_lv), .val(b_val), .tc(b_tc), .at_lim(b_al)
  );
  counter_mod #(.WIDTH(4), .MAX(9), .SATURATE(1)) u_c (
    .clk(clk), .rst(c_rst), .en(c_en), .up(c_up), .clear(c_clear), .load(c_load),
    .load_val(c_lv), .val(c_val), .tc(c_tc), .at_lim(c_al)
  );
  counter_mod #(.WIDTH(4), .MAX(9), .PRESCALE(3)) u_d (
    .clk(clk), .rst(d_rst), .en(d_en), .up(d_up), .clear(d_clear), .load(d_load),
    .load_val(d_lv), .val(d_val), .tc(d_tc), .at_lim(d_al)
  );

  typedef struct {
    logic rst, en, up, clear, load;
    logic [3:0] lv, ev;
    logic etc, eal;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0d want %0d", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] a_ev[5];
    logic a_et[5];
    logic [3:0] c_ev[7];
    logic c_et[7];
    logic d_rs[14], d_e[14];
    logic [3:0] d_ev[14];
    {a_rst, a_en, a_up, a_clear, a_load, a_lv} = '0;
    {b_rst, b_en, b_up, b_clear, b_load, b_lv} = '0;
    {c_rst, c_en, c_up, c_clear, c_load, c_lv} = '0;
    {d_rst, d_en, d_up, d_clear, d_load, d_lv} = '0;
    tbl[0]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 0, 9, 1, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0, 8, 0, 0};
    tbl[3]  = '{0, 1, 0, 0, 0, 0, 7, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 1, 1, 1, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[7]  = '{0, 1, 0, 0, 0, 0, 9, 1, 0};
    tbl[8]  = '{0, 1, 1, 0, 0, 0, 0, 1, 0};
    tbl[9]  = '{0, 1, 1, 1, 1, 5, 0, 0, 0};
    tbl[10] = '{0, 1, 1, 0, 1, 12, 9, 0, 1};
    tbl[11] = '{0, 1, 1, 0, 0, 0, 0, 1, 0};
    tbl[12] = '{0, 1, 0, 0, 1, 15, 9, 0, 0};
    tbl[13] = '{0, 1, 0, 0, 0, 0, 8, 0, 0};
    tbl[14] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 15; i++) begin
      {b_rst, b_en, b_up, b_clear, b_load, b_lv} =
        {tbl[i].rst, tbl[i].en, tbl[i].up, tbl[i].clear, tbl[i].load, tbl[i].lv};
      tick();
      chk("mod9_val", i, b_val, tbl[i].ev);
      chk("mod9_tc", i, b_tc, tbl[i].etc);
      chk("mod9_at_lim", i, b_al, tbl[i].eal);
    end

    // Default 2-bit wrap counter
    {a_rst, a_en, a_up} = 3'b111;
    tick();
    chk("w2_rst_val", 0, a_val, 0);
    chk("w2_rst_tc", 0, a_tc, 0);
    a_rst = 1'b0;
    a_ev = '{1, 2, 3, 0, 1};
    a_et = '{0, 0, 0, 1, 0};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("w2_val", i, a_val, a_ev[i]);
      chk("w2_tc", i, a_tc, a_et[i]);
    end

    // Saturating counter: hold at 9 upward, hold at 0 downward
    c_rst = 1'b1;
    tick();
    {c_rst, c_load, c_lv, c_en, c_up} = {1'b0, 1'b1, 4'd7, 1'b1, 1'b1};
    tick();
    chk("sat_load", 0, c_val, 7);
    c_load = 1'b0;
    c_ev = '{8, 9, 9, 9, 0, 0, 1};
    c_et = '{0, 0, 1, 1, 0, 1, 0};
    for (int i = 0; i < 7; i++) begin
      c_load = (i == 4);
      c_lv = 4'd0;
      c_up = (i < 4) || (i == 6);
      tick();
      chk("sat_val", i, c_val, c_ev[i]);
      chk("sat_tc", i, c_tc, c_et[i]);
    end

    // Prescale 3: en gap preserves phase, mid-run reset restarts a full prescale
    d_rs = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    d_e  = '{1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    d_ev = '{0, 0, 0, 1, 1, 1, 1, 1, 2, 2, 0, 0, 0, 1};
    d_up = 1'b1;
    for (int i = 0; i < 14; i++) begin
      d_rst = d_rs[i];
      d_en = d_e[i];
      tick();
      chk("pre_val", i, d_val, d_ev[i]);
      chk("pre_tc", i, d_tc, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
